img_rsz_row_ser: RTL and testbench

// - Downstream of the resized-pixel forwarder in serial ROW mode.
// - Accepts whole resized rows (any Y order) into a per-row reorder store.
// - Emits them as a raster-order pixel stream (one pixel/cycle) with X/Y position and frame/line flags.
// - Feeds the output image writer / stream interface.

---
 rtl/img_rsz_row_ser_if.sv | 53 +++++
 rtl/img_rsz_row_ser.sv | 155 +++++++++++++++
 tb/tb_img_rsz_row_ser.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/img_rsz_row_ser_if.sv
// Row and pixel stream interfaces for img_rsz_row_ser.
//
// img_rsz_row_ser_row_if : whole resized rows, tagged with their Y index.
//   RowDat  row payload, RowDat[c][x]
//   RowPosY Y index of RowDat
//   RowVld  row valid (master -> slave)
//   RowRdy  row ready (slave -> master)
//
// img_rsz_row_ser_pxl_if : raster pixel stream, one pixel per transfer.
//   PxlDat  pixel payload, color c at [c*W +: W]
//   PxlPosX / PxlPosY  pixel position
//   PxlSof / PxlEol / PxlEof  frame/line flags
//   PxlVld  pixel valid (master -> slave)
//   PxlRdy  pixel ready (slave -> master)

interface img_rsz_row_ser_row_if #(
  parameter int RSZ_IMG_WIDTH_SIZE   = 8,
  parameter int RSZ_IMG_HEIGHT_SIZE  = 8,
  parameter int RSZ_IMG_HEIGHT_IDX_W = $clog2(RSZ_IMG_HEIGHT_SIZE),
  parameter int PXL_PRIM_COLOR_W     = 8,
  parameter int PXL_PRIM_COLOR_NUM   = 1
);
  logic [PXL_PRIM_COLOR_NUM-1:0][RSZ_IMG_WIDTH_SIZE-1:0][PXL_PRIM_COLOR_W-1:0] RowDat;
  logic [RSZ_IMG_HEIGHT_IDX_W-1:0] RowPosY;
  logic                            RowVld;
  logic                            RowRdy;

  modport master (output RowDat, output RowPosY, output RowVld, input RowRdy);
  modport slave  (input RowDat, input RowPosY, input RowVld, output RowRdy);
endinterface

interface img_rsz_row_ser_pxl_if #(
  parameter int RSZ_IMG_WIDTH_SIZE   = 8,
  parameter int RSZ_IMG_HEIGHT_SIZE  = 8,
  parameter int RSZ_IMG_WIDTH_IDX_W  = $clog2(RSZ_IMG_WIDTH_SIZE),
  parameter int RSZ_IMG_HEIGHT_IDX_W = $clog2(RSZ_IMG_HEIGHT_SIZE),
  parameter int PXL_PRIM_COLOR_W     = 8,
  parameter int PXL_PRIM_COLOR_NUM   = 1
);
  logic [PXL_PRIM_COLOR_NUM*PXL_PRIM_COLOR_W-1:0] PxlDat;
  logic [RSZ_IMG_WIDTH_IDX_W-1:0]                 PxlPosX;
  logic [RSZ_IMG_HEIGHT_IDX_W-1:0]                PxlPosY;
  logic                                           PxlSof;
  logic                                           PxlEol;
  logic                                           PxlEof;
  logic                                           PxlVld;
  logic                                           PxlRdy;

  modport master (output PxlDat, output PxlPosX, output PxlPosY, output PxlSof,
                  output PxlEol, output PxlEof, output PxlVld, input PxlRdy);
  modport slave  (input PxlDat, input PxlPosX, input PxlPosY, input PxlSof,
                  input PxlEol, input PxlEof, input PxlVld, output PxlRdy);
endinterface

// File: rtl/img_rsz_row_ser.sv
// img_rsz_row_ser
// Accepts whole resized rows in any Y order into a per-row reorder store and
// serialises them as a raster-order pixel stream (one pixel per cycle) with
// X/Y position and frame/line flags.
//
// Ports:
//   Clk      clock
//   Reset    synchronous, active-high reset (drops stored rows and any
//            partially sent row)
//   row      img_rsz_row_ser_row_if.slave  : incoming rows (RowDat/RowPosY/RowVld/RowRdy)
//   pxl      img_rsz_row_ser_pxl_if.master : outgoing pixels (PxlDat/PxlPosX/PxlPosY/
//            PxlSof/PxlEol/PxlEof/PxlVld/PxlRdy)
//   FrmDone  1-cycle pulse in the cycle after the last pixel of a frame transfers
//   StallCnt saturating count of cycles with PxlVld & ~PxlRdy
//            (present only when IMG_RSZ_ROW_SER_STAT_EN is defined)
//
// Configuration macro: IMG_RSZ_ROW_SER_STAT_EN enables the StallCnt port.

module img_rsz_row_ser #(
  parameter int RSZ_IMG_WIDTH_SIZE   = 8,
  parameter int RSZ_IMG_HEIGHT_SIZE  = 8,
  parameter int RSZ_IMG_WIDTH_IDX_W  = $clog2(RSZ_IMG_WIDTH_SIZE),
  parameter int RSZ_IMG_HEIGHT_IDX_W = $clog2(RSZ_IMG_HEIGHT_SIZE),
  parameter int PXL_PRIM_COLOR_W     = 8,
  parameter int PXL_PRIM_COLOR_NUM   = 1
) (
  input  logic                         Clk,
  input  logic                         Reset,
  img_rsz_row_ser_row_if.slave         row,
  img_rsz_row_ser_pxl_if.master        pxl,
  output logic                         FrmDone
`ifdef IMG_RSZ_ROW_SER_STAT_EN
  ,
  output logic [15:0]                  StallCnt
`endif
);

  localparam int WS = RSZ_IMG_WIDTH_SIZE;
  localparam int HS = RSZ_IMG_HEIGHT_SIZE;
  localparam int XW = RSZ_IMG_WIDTH_IDX_W;
  localparam int YW = RSZ_IMG_HEIGHT_IDX_W;
  localparam int CW = PXL_PRIM_COLOR_W;
  localparam int CN = PXL_PRIM_COLOR_NUM;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [XW-1:0] X_LAST = XW'(WS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HS - 1);

  typedef logic [CN-1:0][WS-1:0][CW-1:0] row_t;

  logic [0:0]    state;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic [HS-1:0] row_pres;
  logic [HS-1:0] row_pres_nxt;
  row_t          row_mem [HS];
  row_t          row_p1;

  logic row_rdy;
  logic row_acc;
  logic row_load;
  logic vld_p1;
  logic pxl_hs;
  logic x_last;

  // Stage 0: row acceptance into the reorder store
  // A slot is free only when its presence bit is clear; an occupied slot
  // backpressures rather than being overwritten. Out-of-range Y never accepts.
  always_comb begin
    row_rdy = 1'b0;
    if (int'(row.RowPosY) < HS) row_rdy = ~row_pres[row.RowPosY];
  end

  assign row.RowRdy = row_rdy;
  assign row_acc    = row.RowVld & row_rdy;
  assign row_load   = (state == ST_IDLE) & row_pres[cur_y];
  assign vld_p1     = (state == ST_SEND);
  assign pxl_hs     = vld_p1 & pxl.PxlRdy;
  assign x_last     = (cur_x == X_LAST);

  // The slot being loaded is already present, so it can never be the slot
  // being accepted in the same cycle; both updates apply independently.
  always_comb begin
    row_pres_nxt = row_pres;
    if (row_load) row_pres_nxt[cur_y] = 1'b0;
    if (row_acc)  row_pres_nxt[row.RowPosY] = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (row_acc) row_mem[row.RowPosY] <= row.RowDat;
    if (row_load) row_p1 <= row_mem[cur_y];
  end

  // Stage 1: raster serialiser FSM
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_IDLE;
      cur_x    <= '0;
      cur_y    <= '0;
      row_pres <= '0;
      FrmDone  <= 1'b0;
    end else begin
      FrmDone  <= 1'b0;
      row_pres <= row_pres_nxt;
      case (state)
        ST_IDLE: begin
          if (row_load) begin
            cur_x <= '0;
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (pxl_hs) begin
            if (x_last) begin
              state   <= ST_IDLE;
              cur_y   <= (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
              FrmDone <= (cur_y == Y_LAST);
            end else begin
              cur_x <= cur_x + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are forced to zero whenever no pixel is offered, so the
  // unreset row register never leaks onto the bus.
  always_comb begin
    pxl.PxlDat = '0;
    if (vld_p1) begin
      for (int c = 0; c < CN; c++) pxl.PxlDat[c*CW +: CW] = row_p1[c][cur_x];
    end
    pxl.PxlVld  = vld_p1;
    pxl.PxlPosX = vld_p1 ? cur_x : '0;
    pxl.PxlPosY = vld_p1 ? cur_y : '0;
    pxl.PxlSof  = vld_p1 & (cur_x == '0) & (cur_y == '0);
    pxl.PxlEol  = vld_p1 & x_last;
    pxl.PxlEof  = vld_p1 & x_last & (cur_y == Y_LAST);
  end

`ifdef IMG_RSZ_ROW_SER_STAT_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      StallCnt <= '0;
    end else if (vld_p1 & ~pxl.PxlRdy & (StallCnt != 16'hFFFF)) begin
      StallCnt <= StallCnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_img_rsz_row_ser.sv
// Directed self-checking bench for img_rsz_row_ser with W=4, H=2, one 8-bit color.

module tb_img_rsz_row_ser;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int XW = 2;
  localparam int YW = 1;

  logic Clk = 1'b0;
  logic Reset;
  logic FrmDone;
`ifdef IMG_RSZ_ROW_SER_STAT_EN
  logic [15:0] StallCnt;
`endif

  img_rsz_row_ser_row_if #(
    .RSZ_IMG_WIDTH_SIZE(W), .RSZ_IMG_HEIGHT_SIZE(H), .RSZ_IMG_HEIGHT_IDX_W(YW),
    .PXL_PRIM_COLOR_W(8), .PXL_PRIM_COLOR_NUM(1)
  ) row ();

  img_rsz_row_ser_pxl_if #(
    .RSZ_IMG_WIDTH_SIZE(W), .RSZ_IMG_HEIGHT_SIZE(H), .RSZ_IMG_WIDTH_IDX_W(XW),
    .RSZ_IMG_HEIGHT_IDX_W(YW), .PXL_PRIM_COLOR_W(8), .PXL_PRIM_COLOR_NUM(1)
  ) pxl ();

  img_rsz_row_ser #(
    .RSZ_IMG_WIDTH_SIZE(W), .RSZ_IMG_HEIGHT_SIZE(H), .RSZ_IMG_WIDTH_IDX_W(XW),
    .RSZ_IMG_HEIGHT_IDX_W(YW), .PXL_PRIM_COLOR_W(8), .PXL_PRIM_COLOR_NUM(1)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .row     (row.slave),
    .pxl     (pxl.master),
    .FrmDone (FrmDone)
`ifdef IMG_RSZ_ROW_SER_STAT_EN
    ,
    .StallCnt(StallCnt)
`endif
  );

  always #5 Clk = ~Clk;

  // PxlRdy source: either a fixed level or a per-cycle toggle
  logic rdy_set = 1'b1;
  logic tog_en  = 1'b0;
  logic tog     = 1'b1;
  assign pxl.PxlRdy = tog_en ? tog : rdy_set;

  always @(posedge Clk) begin
    #1;
    tog = ~tog;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          cyc = 0;
  int          last_hs = 0;
  int          frm_cnt = 0;
  int          frm_exp = 0;
  int          stall_model = 0;
  logic        stall_prev = 1'b0;
  logic        frm_prev = 1'b0;
  logic [31:0] snap;
  logic [31:0] snap_prev = '0;

  function automatic logic [31:0] pack(input logic eof, input logic eol, input logic sof,
                                       input logic [YW-1:0] y, input logic [XW-1:0] x,
                                       input logic [7:0] d);
    return {5'd0, eof, eol, sof, 7'd0, y, 6'd0, x, d};
  endfunction

  // Observer: records transfers, checks stall stability and FrmDone timing
  always @(posedge Clk) begin
    cyc++;
    if (Reset) begin
      stall_prev  = 1'b0;
      stall_model = 0;
      frm_prev    = 1'b0;
    end else begin
      snap = {pxl.PxlVld, 4'd0, pxl.PxlEof, pxl.PxlEol, pxl.PxlSof, 7'd0, pxl.PxlPosY,
              6'd0, pxl.PxlPosX, pxl.PxlDat};
      if (stall_prev) chk("hold", snap, snap_prev);
      if (pxl.PxlVld && pxl.PxlRdy) begin
        got_q.push_back(pack(pxl.PxlEof, pxl.PxlEol, pxl.PxlSof, pxl.PxlPosY, pxl.PxlPosX,
                             pxl.PxlDat));
        last_hs = cyc;
      end
      if (FrmDone) begin
        frm_cnt++;
        chk("frm_gap", cyc - last_hs, 1);
        chk("frm_pulse", {30'd0, frm_prev, FrmDone}, 32'd1);
      end
      if (pxl.PxlVld && !pxl.PxlRdy) stall_model++;
      stall_prev = pxl.PxlVld && !pxl.PxlRdy;
      snap_prev  = snap;
      frm_prev   = FrmDone;
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_row(input int y, input int base);
    logic ok;
    for (int x = 0; x < W; x++) row.RowDat[0][x] = 8'(base + x);
    row.RowPosY = YW'(y);
    row.RowVld  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge Clk);
      if (row.RowRdy) ok = 1'b1;
      step();
    end
    row.RowVld = 1'b0;
    if (!ok) chk("row_accept", {31'd0, row.RowRdy}, 32'd1);
  endtask

  task automatic exp_row(input int y, input int base);
    for (int x = 0; x < W; x++)
      exp_q.push_back(pack(x == W-1 && y == H-1, x == W-1, x == 0 && y == 0,
                           YW'(y), XW'(x), 8'(base + x)));
  endtask

  task automatic wait_frm(input int target);
    for (int i = 0; i < 400 && frm_cnt < target; i++) @(negedge Clk);
    repeat (3) @(negedge Clk);
    chk("frm_cnt", frm_cnt, target);
    step();
  endtask

  task automatic cmp_q(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_pix%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    Reset       = 1'b1;
    row.RowVld  = 1'b0;
    row.RowPosY = '0;
    row.RowDat  = '0;
    repeat (3) step();

    // Reset state
    chk("rst_vld", {31'd0, pxl.PxlVld}, 0);
    chk("rst_frm", {31'd0, FrmDone}, 0);
    chk("rst_dat", {24'd0, pxl.PxlDat}, 0);
    chk("rst_sof", {31'd0, pxl.PxlSof}, 0);
    chk("rst_rdy", {31'd0, row.RowRdy}, 1);
`ifdef IMG_RSZ_ROW_SER_STAT_EN
    chk("rst_stall", {16'd0, StallCnt}, 0);
`endif
    Reset = 1'b0;
    step();

    // In-order frame, with first-pixel latency
    send_row(0, 0);
    chk("lat_t1_vld", {31'd0, pxl.PxlVld}, 0);
    send_row(1, 16);
    chk("lat_t2_vld", {31'd0, pxl.PxlVld}, 1);
    chk("lat_t2_sof", {31'd0, pxl.PxlSof}, 1);
    chk("lat_t2_dat", {24'd0, pxl.PxlDat}, 0);
    chk("lat_t2_x",   {30'd0, pxl.PxlPosX}, 0);
    frm_exp++;
    wait_frm(frm_exp);
    exp_row(0, 0);
    exp_row(1, 16);
    cmp_q("inorder");

    // Out-of-order arrival: Y1 waits until Y0 is present
    send_row(1, 16);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("ooo_novld", {31'd0, pxl.PxlVld}, 0);
    end
    step();
    send_row(0, 0);
    frm_exp++;
    wait_frm(frm_exp);
    exp_row(0, 0);
    exp_row(1, 16);
    cmp_q("ooo");

    // Toggling PxlRdy
    tog_en = 1'b1;
    send_row(0, 0);
    send_row(1, 16);
    frm_exp++;
    wait_frm(frm_exp);
    tog_en = 1'b0;
    exp_row(0, 0);
    exp_row(1, 16);
    cmp_q("toggle");
    chk("stall_seen", {31'd0, stall_model > 0}, 1);
`ifdef IMG_RSZ_ROW_SER_STAT_EN
    chk("stall_cnt_tog", {16'd0, StallCnt}, stall_model);
`endif

    // Occupied slot backpressure while output is stalled
    rdy_set = 1'b0;
    send_row(1, 16);
    for (int x = 0; x < W; x++) row.RowDat[0][x] = 8'(48 + x);
    row.RowPosY = 1'b1;
    row.RowVld  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("occ_rdy", {31'd0, row.RowRdy}, 0);
      step();
    end
    row.RowVld  = 1'b0;
    row.RowPosY = 1'b0;
    #1;
    chk("free_rdy_y0", {31'd0, row.RowRdy}, 1);
    send_row(0, 0);
    repeat (4) step();
    chk("stall_vld", {31'd0, pxl.PxlVld}, 1);
    chk("stall_x",   {30'd0, pxl.PxlPosX}, 0);
    row.RowPosY = 1'b1;
    #1;
    chk("occ_rdy_late", {31'd0, row.RowRdy}, 0);
    rdy_set = 1'b1;
    frm_exp++;
    wait_frm(frm_exp);
    exp_row(0, 0);
    exp_row(1, 16);
    cmp_q("occupied");
`ifdef IMG_RSZ_ROW_SER_STAT_EN
    chk("stall_cnt_hold", {16'd0, StallCnt}, stall_model);
`endif

    // Reset in the middle of a row at X=2
    send_row(0, 0);
    send_row(1, 16);
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (pxl.PxlVld && pxl.PxlPosX == 2'd2 && pxl.PxlPosY == 1'b0) break;
    end
    Reset = 1'b1;
    step();
    chk("mrst_vld", {31'd0, pxl.PxlVld}, 0);
    chk("mrst_frm", {31'd0, FrmDone}, 0);
    row.RowPosY = 1'b0;
    #1;
    chk("mrst_rdy_y0", {31'd0, row.RowRdy}, 1);
    row.RowPosY = 1'b1;
    #1;
    chk("mrst_rdy_y1", {31'd0, row.RowRdy}, 1);
    chk("mrst_partial", got_q.size(), 2);
    got_q.delete();
    Reset = 1'b0;
    step();
    send_row(0, 8'h40);
    send_row(1, 8'h50);
    frm_exp++;
    wait_frm(frm_exp);
    exp_row(0, 8'h40);
    exp_row(1, 8'h50);
    cmp_q("restart");

    // Two back-to-back frames, next-frame rows stored early
    send_row(0, 0);
    send_row(1, 16);
    send_row(0, 8'h80);
    send_row(1, 8'h90);
    frm_exp += 2;
    wait_frm(frm_exp);
    exp_row(0, 0);
    exp_row(1, 16);
    exp_row(0, 8'h80);
    exp_row(1, 8'h90);
    cmp_q("b2b");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
